// File: rtl/isp_ae_pkg.sv
// Shared types and constants for the auto-exposure frame scheduler.
// Gains are unsigned Q8.8 values.
package isp_ae_pkg;

    typedef logic [15:0] gain_t;

    localparam gain_t GainUnity = 16'h0100;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StMeasure = 3'd1;
    localparam logic [2:0] StCapture = 3'd2;
    localparam logic [2:0] StPending = 3'd3;
    localparam logic [2:0] StSettle  = 3'd4;

endpackage

// File: rtl/ae_gain_shadow.sv
// Pending/active gain register pair. The active value only moves on commit, taken either from
// the pending register or from a direct source (manual gain).
module ae_gain_shadow
    import isp_ae_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_gain,
    input  logic        discard,
    input  logic        commit,
    input  logic        use_direct,
    input  logic [15:0] direct_gain,
    output logic [15:0] active,
    output logic        changed
);

    gain_t pending_q;
    gain_t active_q;
    logic  changed_q;
    gain_t commit_gain;

    assign commit_gain = use_direct ? direct_gain : pending_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= GainUnity;
            active_q  <= GainUnity;
            changed_q <= 1'b0;
        end else begin
            changed_q <= commit && (commit_gain != active_q);
            if (commit) begin
                active_q <= commit_gain;
            end
            if (discard) begin
                pending_q <= GainUnity;
            end else if (load) begin
                pending_q <= load_gain;
            end
        end
    end

    assign active  = active_q;
    assign changed = changed_q;

endmodule

// File: rtl/ae_frame_scheduler.sv
// Frame-level sequencer: forwards statistics to the AE controller, shadows its gain onto frame
// boundaries, discards settling frames and reports lock.
module ae_frame_scheduler
    import isp_ae_pkg::*;
#(
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned CTRL_LATENCY  = 2,
    parameter int unsigned LOCK_FRAMES   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        stats_valid,
    input  logic        ae_enable,
    input  logic        manual_mode,
    input  logic [15:0] manual_gain,
    input  logic [15:0] ctrl_gain,
    output logic        ctrl_frame_done,
    output logic [15:0] gain_out,
    output logic        gain_update,
    output logic        locked,
    output logic [2:0]  state
);

    logic [2:0] state_q, state_d;
    logic [2:0] lat_q, lat_d;
    logic [3:0] stable_q, stable_d;
    logic [3:0] settle_q, settle_d;
    logic       cfd_q, cfd_d;
    logic       locked_q, locked_d;

    logic  abort;
    logic  load;
    logic  discard;
    logic  commit;
    logic  use_direct;
    logic  clear_lock;
    gain_t active_gain;

    assign abort = (state_q != StIdle) && (!ae_enable || manual_mode);

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        stable_d   = stable_q;
        settle_d   = settle_q;
        cfd_d      = 1'b0;
        load       = 1'b0;
        discard    = 1'b0;
        commit     = 1'b0;
        use_direct = 1'b0;
        clear_lock = 1'b0;

        if (abort) begin
            // Override wins over any event in the same cycle; gain_out is left untouched.
            state_d    = StIdle;
            lat_d      = 3'd0;
            stable_d   = 4'd0;
            settle_d   = 4'd0;
            discard    = 1'b1;
            clear_lock = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        if (manual_mode) begin
                            commit     = 1'b1;
                            use_direct = 1'b1;
                            clear_lock = 1'b1;
                        end else if (ae_enable) begin
                            state_d = StMeasure;
                        end
                    end
                end
                StMeasure: begin
                    if (stats_valid) begin
                        cfd_d   = 1'b1;
                        lat_d   = 3'd0;
                        state_d = StCapture;
                    end
                end
                StCapture: begin
                    if (lat_q == 3'(CTRL_LATENCY)) begin
                        lat_d = 3'd0;
                        if (ctrl_gain == active_gain) begin
                            stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
                            state_d  = StMeasure;
                        end else begin
                            stable_d = 4'd0;
                            load     = 1'b1;
                            state_d  = StPending;
                        end
                    end else begin
                        lat_d = lat_q + 3'd1;
                    end
                end
                StPending: begin
                    if (frame_start) begin
                        commit     = 1'b1;
                        clear_lock = 1'b1;
                        settle_d   = 4'(SETTLE_FRAMES);
                        state_d    = (SETTLE_FRAMES == 0) ? StMeasure : StSettle;
                    end
                end
                StSettle: begin
                    if (stats_valid) begin
                        if (settle_q <= 4'd1) begin
                            settle_d = 4'd0;
                            state_d  = StMeasure;
                        end else begin
                            settle_d = settle_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        locked_d = clear_lock ? 1'b0 : (stable_d >= 4'(LOCK_FRAMES));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lat_q    <= 3'd0;
            stable_q <= 4'd0;
            settle_q <= 4'd0;
            cfd_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            stable_q <= stable_d;
            settle_q <= settle_d;
            cfd_q    <= cfd_d;
            locked_q <= locked_d;
        end
    end

    ae_gain_shadow u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_gain  (ctrl_gain),
        .discard    (discard),
        .commit     (commit),
        .use_direct (use_direct),
        .direct_gain(manual_gain),
        .active     (active_gain),
        .changed    (gain_update)
    );

    assign gain_out        = active_gain;
    assign ctrl_frame_done = cfd_q;
    assign locked          = locked_q;
    assign state           = state_q;

endmodule

// File: tb/tb_ae_frame_scheduler.sv
// Directed bench for ae_frame_scheduler with default parameters (settle 2, latency 2, lock 4).
module tb_ae_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        stats_valid = 1'b0;
    logic        ae_enable = 1'b0;
    logic        manual_mode = 1'b0;
    logic [15:0] manual_gain = 16'h0100;
    logic [15:0] ctrl_gain = 16'h0100;
    logic        ctrl_frame_done;
    logic [15:0] gain_out;
    logic        gain_update;
    logic        locked;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ae_frame_scheduler #(
        .SETTLE_FRAMES(2),
        .CTRL_LATENCY (2),
        .LOCK_FRAMES  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .stats_valid    (stats_valid),
        .ae_enable      (ae_enable),
        .manual_mode    (manual_mode),
        .manual_gain    (manual_gain),
        .ctrl_gain      (ctrl_gain),
        .ctrl_frame_done(ctrl_frame_done),
        .gain_out       (gain_out),
        .gain_update    (gain_update),
        .locked         (locked),
        .state          (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic fs, input logic sv);
        frame_start = fs;
        stats_valid = sv;
        tick();
        frame_start = 1'b0;
        stats_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ae_enable = 1'b0;
        manual_mode = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Bounded: a stuck CAPTURE shows up as a wrong state or latency in the caller's checks.
    task automatic wait_capture(output int n);
        n = 0;
        while (state == 3'd2 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (gain_out !== 16'h0100) begin bad++; $display("FAIL reset_gain got=%h want=0100", gain_out); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if ({locked, gain_update, ctrl_frame_done} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {locked, gain_update, ctrl_frame_done});
        end
        pulse(1'b0, 1'b1);
        total++; if ({state, ctrl_frame_done} !== 4'b0000) begin
            bad++; $display("FAIL idle_ignores_stats got=%b want=0000", {state, ctrl_frame_done});
        end
    endtask

    task automatic test_commit();
        int n;
        int ups;
        do_reset();
        ae_enable = 1'b1;
        ctrl_gain = 16'h0104;
        pulse(1'b1, 1'b0);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL commit_enter_measure got=%0d want=1", state); end
        pulse(1'b0, 1'b1);
        total++; if ({state, ctrl_frame_done} !== 4'b0101) begin
            bad++; $display("FAIL commit_cfd got=%b want=0101", {state, ctrl_frame_done});
        end
        wait_capture(n);
        total++; if (n !== 3) begin bad++; $display("FAIL commit_capture_len got=%0d want=3", n); end
        total++; if (state !== 3'd3) begin bad++; $display("FAIL commit_pending got=%0d want=3", state); end
        total++; if (gain_out !== 16'h0100) begin bad++; $display("FAIL commit_hold got=%h want=0100", gain_out); end
        pulse(1'b1, 1'b0);
        total++; if (gain_out !== 16'h0104) begin bad++; $display("FAIL commit_gain got=%h want=0104", gain_out); end
        total++; if (gain_update !== 1'b1) begin bad++; $display("FAIL commit_update got=%b want=1", gain_update); end
        total++; if (state !== 3'd4) begin bad++; $display("FAIL commit_settle got=%0d want=4", state); end
        ups = 0;
        repeat (5) begin
            tick();
            if (gain_update) ups++;
        end
        total++; if (ups !== 0) begin bad++; $display("FAIL commit_single_pulse got=%0d want=0", ups); end
    endtask

    // Continues from SETTLE left by test_commit.
    task automatic test_settle();
        int n;
        pulse(1'b0, 1'b1);
        total++; if ({state, ctrl_frame_done} !== 4'b1000) begin
            bad++; $display("FAIL settle_first got=%b want=1000", {state, ctrl_frame_done});
        end
        pulse(1'b0, 1'b1);
        total++; if ({state, ctrl_frame_done} !== 4'b0010) begin
            bad++; $display("FAIL settle_second got=%b want=0010", {state, ctrl_frame_done});
        end
        pulse(1'b0, 1'b1);
        total++; if (ctrl_frame_done !== 1'b1) begin bad++; $display("FAIL settle_third got=%b want=1", ctrl_frame_done); end
        wait_capture(n);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL settle_remeasure got=%0d want=1", state); end
    endtask

    task automatic test_lock();
        int n;
        logic exp_lk;
        do_reset();
        ae_enable = 1'b1;
        ctrl_gain = 16'h0100;
        pulse(1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            pulse(1'b0, 1'b1);
            wait_capture(n);
            exp_lk = (i >= 4) ? 1'b1 : 1'b0;
            total++; if (locked !== exp_lk) begin
                bad++; $display("FAIL lock_meas%0d got=%b want=%b", i, locked, exp_lk);
            end
        end
        // Second stats_valid during CAPTURE must be dropped.
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        total++; if (ctrl_frame_done !== 1'b0) begin bad++; $display("FAIL drop_cfd got=%b want=0", ctrl_frame_done); end
        wait_capture(n);
        tick();
        total++; if ({state, ctrl_frame_done, locked} !== 5'b00101) begin
            bad++; $display("FAIL drop_no_queue got=%b want=00101", {state, ctrl_frame_done, locked});
        end
        ctrl_gain = 16'h0108;
        pulse(1'b0, 1'b1);
        wait_capture(n);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL lock_change_pending got=%0d want=3", state); end
        pulse(1'b1, 1'b0);
        total++; if ({gain_out, gain_update, locked} !== {16'h0108, 2'b10}) begin
            bad++; $display("FAIL lock_commit got=%h/%b/%b want=0108/1/0", gain_out, gain_update, locked);
        end
    endtask

    task automatic test_manual();
        int n;
        do_reset();
        ae_enable = 1'b1;
        ctrl_gain = 16'h0104;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_capture(n);
        manual_gain = 16'h0200;
        manual_mode = 1'b1;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL manual_to_idle got=%0d want=0", state); end
        tick();
        total++; if (gain_out !== 16'h0100) begin bad++; $display("FAIL manual_hold got=%h want=0100", gain_out); end
        pulse(1'b1, 1'b0);
        total++; if ({gain_out, gain_update} !== {16'h0200, 1'b1}) begin
            bad++; $display("FAIL manual_commit got=%h/%b want=0200/1", gain_out, gain_update);
        end
        pulse(1'b1, 1'b0);
        total++; if ({gain_out, gain_update} !== {16'h0200, 1'b0}) begin
            bad++; $display("FAIL manual_same got=%h/%b want=0200/0", gain_out, gain_update);
        end
        manual_mode = 1'b0;
        pulse(1'b1, 1'b0);
        total++; if ({state, gain_out} !== {3'd1, 16'h0200}) begin
            bad++; $display("FAIL manual_discard got=%0d/%h want=1/0200", state, gain_out);
        end
        ae_enable = 1'b0;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL abort_disable got=%0d want=0", state); end
    endtask

    task automatic test_same_cycle();
        int n;
        do_reset();
        ae_enable = 1'b1;
        ctrl_gain = 16'h0104;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        total++; if ({state, ctrl_frame_done} !== 4'b0101) begin
            bad++; $display("FAIL same_measure got=%b want=0101", {state, ctrl_frame_done});
        end
        wait_capture(n);
        pulse(1'b1, 1'b1);
        total++; if ({state, gain_out, gain_update} !== {3'd4, 16'h0104, 1'b1}) begin
            bad++; $display("FAIL same_pending got=%0d/%h/%b want=4/0104/1", state, gain_out, gain_update);
        end
        pulse(1'b1, 1'b0);
        total++; if (state !== 3'd4) begin bad++; $display("FAIL settle_fs_only got=%0d want=4", state); end
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        total++; if ({state, ctrl_frame_done, gain_update} !== 5'b00100) begin
            bad++; $display("FAIL same_settle got=%b want=00100", {state, ctrl_frame_done, gain_update});
        end
        tick();
        total++; if ({state, ctrl_frame_done} !== 4'b0010) begin
            bad++; $display("FAIL same_settle_fs_unused got=%b want=0010", {state, ctrl_frame_done});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        ae_enable = 1'b1;
        ctrl_gain = 16'h0104;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_capture(n);
        pulse(1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if ({gain_out, state, locked, gain_update} !== {16'h0100, 3'd0, 2'b00}) begin
            bad++; $display("FAIL reset_mid got=%h/%0d/%b/%b want=0100/0/0/0", gain_out, state, locked, gain_update);
        end
        pulse(1'b1, 1'b0);
        total++; if ({state, gain_out} !== {3'd1, 16'h0100}) begin
            bad++; $display("FAIL reset_mid_lost got=%0d/%h want=1/0100", state, gain_out);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_settle();
        test_lock();
        test_manual();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ae_frame_scheduler.md
# ae_frame_scheduler

Frame-level sequencer between the AE statistics block, the AE gain controller and the gain-multiply datapath. It forwards a statistics frame to the controller only when that frame was exposed with the currently applied gain. It captures the controller's new gain and commits it to the datapath only on a frame boundary, through a shadow register. It then discards a configurable number of settling frames before measuring again, and reports lock and manual-override status.

## Interface
Parameters:
- SETTLE_FRAMES, 2: statistics frames discarded after each gain commit (0..15).
- CTRL_LATENCY, 2: cycles from `ctrl_frame_done` to a valid `ctrl_gain` (1..7).
- LOCK_FRAMES, 4: consecutive unchanged measurements needed to assert `locked` (1..15).

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync rise)
- stats_valid  in  1  one-cycle pulse: statistics for the just-ended frame are valid
- ae_enable  in  1  level: auto exposure enabled
- manual_mode  in  1  level: override with `manual_gain`
- manual_gain  in  16  Q8.8 manual gain
- ctrl_gain  in  16  Q8.8 gain output of the AE controller
- ctrl_frame_done  out  1  one-cycle pulse to the controller's frame-done input
- gain_out  out  16  Q8.8 gain applied by the datapath (shadowed)
- gain_update  out  1  one-cycle pulse when `gain_out` changes
- locked  out  1  AE converged
- state  out  3  current FSM state (debug)

## Operation
Reset values: `gain_out` = 16'h0100, `ctrl_frame_done` = 0, `gain_update` = 0, `locked` = 0, `state` = IDLE. All internal counters reset to 0.

FSM states:
- IDLE
  - On `frame_start` with `manual_mode` = 1: commit `manual_gain` to `gain_out`, and pulse `gain_update` only if the value differs.
  - On `frame_start` with `ae_enable` = 1 and `manual_mode` = 0: go to MEASURE.
- MEASURE
  - On `stats_valid`: pulse `ctrl_frame_done` and go to CAPTURE.
- CAPTURE
  - Count CTRL_LATENCY cycles, then sample `ctrl_gain` into `pending_gain`.
  - If `pending_gain` == `gain_out`: increment `stable_cnt` (saturating at 15) and go to MEASURE.
  - Otherwise: clear `stable_cnt` and go to PENDING.
  - `stats_valid` and `frame_start` are ignored in this state.
- PENDING
  - On `frame_start`: `gain_out` <= `pending_gain`, pulse `gain_update`, load `settle_cnt` = SETTLE_FRAMES.
  - Next state is SETTLE, or MEASURE when SETTLE_FRAMES = 0.
  - `stats_valid` is ignored in this state.
- SETTLE
  - Each `stats_valid` decrements `settle_cnt` and is not forwarded.
  - The pulse that brings `settle_cnt` to 0 moves the FSM to MEASURE.

`locked` = (`stable_cnt` >= LOCK_FRAMES), registered. It clears on any commit and on exit to IDLE.

Override and abort:
- `ae_enable` = 0 or `manual_mode` = 1, in any non-IDLE state, moves the FSM to IDLE on the next cycle.
- On that exit: `pending_gain` is discarded, `stable_cnt` and `settle_cnt` are cleared, and `gain_out` holds its value until the next `frame_start`.

Widths and arithmetic:
- Gains are passed through unmodified; range clamping is the controller's job.
- Comparisons are 16-bit unsigned.

## Timing
- `ctrl_frame_done` is registered: it rises the cycle after `stats_valid`.
- `ctrl_gain` is sampled CTRL_LATENCY cycles after `ctrl_frame_done` rises.
- `gain_out` and `gain_update` change the cycle after the accepted `frame_start`. `gain_out` never changes at any other time.
- `frame_start` and `stats_valid` in the same cycle:
  - In MEASURE, `stats_valid` is served.
  - In PENDING, the commit is served.
  - In SETTLE, the decrement happens; if it reaches 0, the FSM enters MEASURE. This `frame_start` is not used for anything.
- A second `stats_valid` arriving during CAPTURE is dropped; no queueing.
- Reset asserted mid-operation returns everything to the reset values on the next clock edge. A pending gain is lost.

## Structure
- Package `isp_ae_pkg`:
  - FSM state encodings (IDLE = 0, MEASURE = 1, CAPTURE = 2, PENDING = 3, SETTLE = 4).
  - Q8.8 unity constant 16'h0100.
  - The gain typedef (16-bit Q8.8).
- Sub-module `ae_gain_shadow`: pending/active register pair with a `commit` input and `changed` output. It is reused for manual-mode commits.

## Test plan
- Reset, then ae_enable = 1, `ctrl_gain` = 16'h0104 → after one MEASURE, `gain_out` = 16'h0104 one cycle after the next `frame_start`, `gain_update` pulses once.
- SETTLE_FRAMES = 2 → the two `stats_valid` pulses after a commit produce no `ctrl_frame_done`; the third one does, one cycle later.
- `ctrl_gain` constant at 16'h0100 for 4 measurements → `locked` = 1 after the 4th. Then change to 16'h0108 → `locked` = 0 on commit.
- `manual_mode` asserted in PENDING with `manual_gain` = 16'h0200 → FSM to IDLE, pending gain discarded, `gain_out` = 16'h0200 after the next `frame_start`.
- `frame_start` and `stats_valid` in the same cycle, checked in MEASURE, PENDING and SETTLE → respective behaviour as specified in Timing.
- rst_n low for one cycle during SETTLE → `gain_out` = 16'h0100, `state` = IDLE, `locked` = 0 on the next edge.
